// File: rtl/lane_stripe_writer.sv
// Frame-buffer writer for a 1 bpp display: scans every pixel address and paints
// scrolling dashed stripes into NUM_LANES vertical lane columns, with a full-frame lane erase.
module lane_stripe_writer #(
    parameter int H_RES       = 320,
    parameter int V_RES       = 240,
    parameter int H_ADDR_WDTH = 9,
    parameter int V_ADDR_WDTH = 8,
    parameter int NUM_LANES   = 2,
    parameter int LANE_X0     = 100,
    parameter int LANE_PITCH  = 115,
    parameter int LANE_WIDTH  = 6,
    parameter int INTERVAL    = 40,
    parameter int STRIPE_LEN  = 20,
    parameter int PRESCALE    = 1499999
) (
    input  logic                               CLK,
    input  logic                               RESET,
    input  logic                               ENABLE,
    input  logic                               DIR,
    input  logic [5:0]                         SPEED,
    input  logic                               CLEAR,
    output logic                               WE,
    output logic [V_ADDR_WDTH+H_ADDR_WDTH-1:0] ADDR,
    output logic                               DATA_OUT,
    output logic                               BUSY,
    output logic                               FRAME_START,
    output logic [7:0]                         OFFSET
);

    localparam int PRE_W = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;

    typedef enum logic {
        DRAW  = 1'b0,
        ERASE = 1'b1
    } state_t;

    logic [H_ADDR_WDTH-1:0] h;
    logic [V_ADDR_WDTH-1:0] v;
    logic [PRE_W-1:0]       pre_cnt;
    logic                   tick_pending;
    logic                   clear_pending;
    logic [7:0]             phase;
    state_t                 state;

    logic       h_last;
    logic       v_last;
    logic       frame_end;
    logic       pre_wrap;
    logic       clear_req;
    logic       do_step;
    logic [7:0] step;
    logic [8:0] sum_down;
    logic [7:0] offset_down;
    logic [7:0] offset_up;
    logic [7:0] offset_next;
    logic [7:0] phase_base;
    logic [7:0] phase_inc;
    logic       stripe_row;
    logic       lane_hit;

    assign h_last    = (h == H_ADDR_WDTH'(H_RES - 1));
    assign v_last    = (v == V_ADDR_WDTH'(V_RES - 1));
    assign frame_end = h_last && v_last;
    assign pre_wrap  = (pre_cnt == PRE_W'(PRESCALE));
    assign clear_req = clear_pending || CLEAR;

    // A tick landing on the boundary cycle itself still counts for this frame.
    assign do_step = (tick_pending || pre_wrap) && ENABLE && (state == DRAW) && !clear_req;

    assign step        = ({2'b00, SPEED} > 8'(INTERVAL - 1)) ? 8'(INTERVAL - 1) : {2'b00, SPEED};
    assign sum_down    = {1'b0, OFFSET} + {1'b0, step};
    assign offset_down = (sum_down >= 9'(INTERVAL)) ? 8'(sum_down - 9'(INTERVAL)) : sum_down[7:0];
    assign offset_up   = (OFFSET >= step) ? (OFFSET - step) : (OFFSET + 8'(INTERVAL) - step);
    assign offset_next = do_step ? (DIR ? offset_up : offset_down) : OFFSET;

    // Row 0 starts at the phase that puts the stripe start OFFSET rows down.
    assign phase_base = (offset_next == 8'd0) ? 8'd0 : (8'(INTERVAL) - offset_next);
    assign phase_inc  = (phase == 8'(INTERVAL - 1)) ? 8'd0 : (phase + 8'd1);
    assign stripe_row = (phase < 8'(STRIPE_LEN));

    always_comb begin
        // NOTE: default before the loop so no path leaves lane_hit unassigned (no latch).
        lane_hit = 1'b0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if ((int'(h) >= LANE_X0 + k * LANE_PITCH) &&
                (int'(h) <  LANE_X0 + k * LANE_PITCH + LANE_WIDTH))
                lane_hit = 1'b1;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            h             <= '0;
            v             <= '0;
            pre_cnt       <= '0;
            tick_pending  <= 1'b0;
            clear_pending <= 1'b0;
            phase         <= 8'd0;
            state         <= DRAW;
            OFFSET        <= 8'd0;
            WE            <= 1'b0;
            ADDR          <= '0;
            DATA_OUT      <= 1'b1;
            BUSY          <= 1'b0;
            FRAME_START   <= 1'b0;
        end else begin
            h <= h_last ? '0 : h + 1'b1;
            if (h_last) begin
                v     <= v_last ? '0 : v + 1'b1;
                phase <= v_last ? phase_base : phase_inc;
            end

            pre_cnt <= pre_wrap ? '0 : pre_cnt + 1'b1;
            if (frame_end)
                tick_pending <= 1'b0;
            else if (pre_wrap)
                tick_pending <= 1'b1;

            if (frame_end) begin
                OFFSET <= offset_next;
                case (state)
                    DRAW: begin
                        if (clear_req) begin
                            state         <= ERASE;
                            clear_pending <= 1'b0;
                        end
                    end
                    ERASE: begin
                        state         <= DRAW;
                        clear_pending <= clear_req;
                    end
                    default: state <= DRAW;
                endcase
            end else if (CLEAR) begin
                clear_pending <= 1'b1;
            end

            // Output stage: all four registered from the same scan state, so they stay aligned.
            ADDR        <= {v, h};
            FRAME_START <= (h == '0) && (v == '0);
            BUSY        <= (state == ERASE);
            WE          <= lane_hit;
            DATA_OUT    <= !(lane_hit && (state == DRAW) && stripe_row);
        end
    end

endmodule

// File: tb/tb_lane_stripe_writer.sv
// Self-checking bench for lane_stripe_writer: frame-level reference model of offset,
// erase frames and stripe geometry, checked pixel by pixel on the output stream.
module tb_lane_stripe_writer;

    localparam int H_RES      = 16;
    localparam int V_RES      = 12;
    localparam int NUM_LANES  = 2;
    localparam int LANE_X0    = 2;
    localparam int LANE_PITCH = 8;
    localparam int LANE_WIDTH = 2;
    localparam int INTERVAL   = 6;
    localparam int STRIPE_LEN = 2;
    localparam int PRESCALE   = 3;
    localparam int FRAME      = H_RES * V_RES;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        ENABLE;
    logic        DIR;
    logic [5:0]  SPEED;
    logic        CLEAR;
    logic        WE;
    logic [16:0] ADDR;
    logic        DATA_OUT;
    logic        BUSY;
    logic        FRAME_START;
    logic [7:0]  OFFSET;

    int checks   = 0;
    int failures = 0;

    // Reference model state, one value per output frame.
    int m_off;
    bit m_erase;
    bit m_pend;

    always #5 CLK = ~CLK;

    lane_stripe_writer #(
        .H_RES(H_RES), .V_RES(V_RES), .H_ADDR_WDTH(9), .V_ADDR_WDTH(8),
        .NUM_LANES(NUM_LANES), .LANE_X0(LANE_X0), .LANE_PITCH(LANE_PITCH),
        .LANE_WIDTH(LANE_WIDTH), .INTERVAL(INTERVAL), .STRIPE_LEN(STRIPE_LEN),
        .PRESCALE(PRESCALE)
    ) dut (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .DIR(DIR), .SPEED(SPEED),
        .CLEAR(CLEAR), .WE(WE), .ADDR(ADDR), .DATA_OUT(DATA_OUT), .BUSY(BUSY),
        .FRAME_START(FRAME_START), .OFFSET(OFFSET)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_lane(input int x);
        for (int k = 0; k < NUM_LANES; k++)
            if (x >= LANE_X0 + k * LANE_PITCH && x < LANE_X0 + k * LANE_PITCH + LANE_WIDTH)
                return 1'b1;
        return 1'b0;
    endfunction

    // Stripe starts OFFSET rows below row 0 and repeats every INTERVAL rows.
    function automatic bit dark_row(input int y, input int off);
        return ((y - off + INTERVAL) % INTERVAL) < STRIPE_LEN;
    endfunction

    function automatic int stepped(input int off, input bit dir, input int sp);
        int s;
        s = (sp > INTERVAL - 1) ? INTERVAL - 1 : sp;
        return dir ? (off - s + INTERVAL) % INTERVAL : (off + s) % INTERVAL;
    endfunction

    // Entered with output on pixel 0 of a frame; leaves on pixel 0 of the next.
    // PRESCALE+1 is far shorter than a frame, so a tick is always pending at the boundary.
    task automatic run_frame(input string name, input bit en, input bit dir,
                             input int sp, input int clear_at);
        int  x, y;
        bit  exp_data;
        ENABLE = en;
        DIR    = dir;
        SPEED  = 6'(sp);
        check({name, "_offset"}, OFFSET, m_off);
        for (int p = 0; p < FRAME; p++) begin
            x = p % H_RES;
            y = p / H_RES;
            exp_data = in_lane(x) ? (m_erase ? 1'b1 : !dark_row(y, m_off)) : 1'b1;
            check($sformatf("%s_addr@%0d", name, p), ADDR, {8'(y), 9'(x)});
            check($sformatf("%s_fs@%0d", name, p), FRAME_START, (p == 0));
            check($sformatf("%s_busy@%0d", name, p), BUSY, m_erase);
            check($sformatf("%s_we@%0d", name, p), WE, in_lane(x));
            check($sformatf("%s_data@%0d", name, p), DATA_OUT, exp_data);
            CLEAR = (p == clear_at);
            @(posedge CLK);
            #1;
        end
        CLEAR = 1'b0;
        if (clear_at >= 0)
            m_pend = 1'b1;
        if (m_erase)
            m_erase = 1'b0;
        else if (m_pend) begin
            m_erase = 1'b1;
            m_pend  = 1'b0;
        end else if (en)
            m_off = stepped(m_off, dir, sp);
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_we"}, WE, 1'b0);
        check({name, "_data"}, DATA_OUT, 1'b1);
        check({name, "_addr"}, ADDR, 17'd0);
        check({name, "_busy"}, BUSY, 1'b0);
        check({name, "_fs"}, FRAME_START, 1'b0);
        check({name, "_offset"}, OFFSET, 8'd0);
    endtask

    initial begin
        int  cyc;
        bit  found;
        RESET  = 1'b1;
        ENABLE = 1'b0;
        DIR    = 1'b0;
        SPEED  = 6'd0;
        CLEAR  = 1'b0;
        m_off  = 0;
        m_erase = 1'b0;
        m_pend  = 1'b0;

        repeat (3) @(posedge CLK);
        #1;
        check_reset_values("rst_hold");

        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        check("first_addr", ADDR, 17'd0);
        check("first_fs", FRAME_START, 1'b1);

        // Static pattern: offset stays 0.
        for (int i = 0; i < 3; i++)
            run_frame("static", 1'b0, 1'b0, 0, -1);
        check("static_off_const", OFFSET, 8'd0);

        // Down scroll, speed 1: frames show offsets 0, 1, 2.
        run_frame("down0", 1'b1, 1'b0, 1, -1);
        check("down_off1", OFFSET, 8'd1);
        run_frame("down1", 1'b1, 1'b0, 1, -1);
        check("down_off2", OFFSET, 8'd2);

        // Wrap and clamp.
        run_frame("to5", 1'b1, 1'b0, 3, -1);
        check("off_5", OFFSET, 8'd5);
        run_frame("wrap_down", 1'b1, 1'b0, 2, -1);
        check("off_5_plus2", OFFSET, 8'd1);
        run_frame("wrap_up", 1'b1, 1'b1, 3, -1);
        check("off_1_minus3", OFFSET, 8'd4);
        run_frame("clamp", 1'b1, 1'b0, 9, -1);
        check("off_4_plus_clamped", OFFSET, 8'd3);

        // Mid-frame clear: next frame erases with offset held, then stripes resume.
        run_frame("clr_req", 1'b1, 1'b0, 1, 50);
        check("erase_busy", BUSY, 1'b1);
        check("erase_off_held", OFFSET, 8'd3);
        run_frame("erase", 1'b1, 1'b0, 1, -1);
        check("resume_busy", BUSY, 1'b0);
        check("resume_off", OFFSET, 8'd3);

        // Clear on the boundary cycle with a tick pending: erase wins, no step.
        run_frame("simul", 1'b1, 1'b0, 2, FRAME - 2);
        check("simul_busy", BUSY, 1'b1);
        check("simul_off", OFFSET, 8'd3);

        // Clear during an erase frame buys one more erase frame after a draw frame.
        run_frame("erase_clr", 1'b1, 1'b0, 1, 20);
        run_frame("between", 1'b1, 1'b0, 1, -1);
        check("second_erase_busy", BUSY, 1'b1);
        run_frame("erase2", 1'b1, 1'b0, 1, -1);
        run_frame("pre_rst", 1'b1, 1'b0, 2, -1);
        check("pre_rst_off", OFFSET, 8'd5);

        // Reset pulse in the middle of a frame at ADDR = {5,7}.
        ENABLE = 1'b0;
        found  = 1'b0;
        for (cyc = 0; cyc < 2 * FRAME && !found; cyc++) begin
            if (ADDR == {8'd5, 9'd7})
                found = 1'b1;
            else begin
                @(posedge CLK);
                #1;
            end
        end
        check("mid_rst_reach", found, 1'b1);
        RESET = 1'b1;
        #1;
        check_reset_values("mid_rst");
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        check("mid_rst_addr", ADDR, 17'd0);
        check("mid_rst_fs", FRAME_START, 1'b1);
        m_off   = 0;
        m_erase = 1'b0;
        m_pend  = 1'b0;
        run_frame("after_rst", 1'b0, 1'b0, 0, -1);

        // Randomized frames against the model.
        for (int i = 0; i < 12; i++) begin
            run_frame($sformatf("rnd%0d", i), 1'($urandom_range(0, 3) != 0),
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
                      ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, FRAME - 2)) : -1);
        end
        run_frame("final", 1'b0, 1'b0, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lane_stripe_writer.md
Name: lane_stripe_writer

Overview:
- Frame-buffer writer for the 320x240, 1 bpp VGA display.
- Continuously scans every pixel address and writes an animated dashed-stripe pattern into NUM_LANES vertical lane columns.
- Stripes scroll up or down at a programmable speed; the scroll offset changes only at frame boundaries, so no tearing.
- Sits between the control logic and the frame-buffer write port. Adds direction, variable speed, multi-lane, and a full-frame lane erase compared with the earlier fixed two-lane writer.

Parameters:
- H_RES, 320, pixels per row
- V_RES, 240, rows per frame
- H_ADDR_WDTH, 9, horizontal address bits
- V_ADDR_WDTH, 8, vertical address bits
- NUM_LANES, 2, number of lane columns (1..8)
- LANE_X0, 100, left x of lane 0
- LANE_PITCH, 115, x distance between lane left edges
- LANE_WIDTH, 6, lane column width in pixels
- INTERVAL, 40, stripe period in rows
- STRIPE_LEN, 20, dark rows per period (< INTERVAL)
- PRESCALE, 1499999, motion tick every PRESCALE+1 clocks

Ports:
- CLK  in  1  system clock
- RESET  in  1  reset, asynchronous, active-high
- ENABLE  in  1  motion enable
- DIR  in  1  0 = stripes move down (+y), 1 = up
- SPEED  in  6  rows per motion step
- CLEAR  in  1  request one erase frame
- WE  out  1  frame-buffer write enable
- ADDR  out  17  {V[7:0], H[8:0]}
- DATA_OUT  out  1  pixel value, 0 = dark stripe, 1 = background
- BUSY  out  1  high during an erase frame
- FRAME_START  out  1  one-cycle pulse when output ADDR = 0
- OFFSET  out  8  current scroll offset

Behaviour:
- Reset values (asynchronous; any register may be mid-operation when RESET asserts): WE=0, DATA_OUT=1, ADDR=0, BUSY=0, FRAME_START=0, OFFSET=0. Scan counters, prescaler, pending flags, row phase and state are all 0.
- Scan:
  - H counts 0..H_RES-1 every CLK.
  - V increments when H wraps; V wraps V_RES-1 -> 0.
  - Frame boundary = cycle with H=H_RES-1 and V=V_RES-1.
- Pipeline: ADDR, WE, DATA_OUT, FRAME_START are registered from the same scan state, so they are mutually aligned. Latency is one cycle from scan state. The first post-reset edge outputs ADDR=0 with FRAME_START=1.
- Prescaler: counts 0..PRESCALE, wraps, and sets tick_pending at the wrap. Multiple ticks within one frame collapse into one step.
- Offset update at the frame boundary:
  - Update only if tick_pending && ENABLE && state=DRAW.
  - Effective step s = min(SPEED, INTERVAL-1).
  - DIR=0: OFFSET = (OFFSET + s) mod INTERVAL.
  - DIR=1: OFFSET = (OFFSET - s) mod INTERVAL, wrapping non-negative.
  - tick_pending clears at every frame boundary regardless of ENABLE.
  - DIR and SPEED are sampled only at the boundary.
- Row phase, with no divider:
  - At V=0, phase = (INTERVAL - OFFSET) mod INTERVAL.
  - Each row increment: phase = phase+1, wrapping INTERVAL-1 -> 0.
  - stripe_row = phase < STRIPE_LEN.
- Lane hit: some k < NUM_LANES with LANE_X0 + k*LANE_PITCH <= H < LANE_X0 + k*LANE_PITCH + LANE_WIDTH. Lanes extending past H_RES are truncated.
- Output per pixel:
  - DRAW, lane hit: WE=1, DATA_OUT = ~stripe_row.
  - ERASE, lane hit: WE=1, DATA_OUT=1.
  - Not a lane: WE=0, DATA_OUT=1.
- States:
  - DRAW -> ERASE at a frame boundary if clear_pending.
  - ERASE -> DRAW at the next frame boundary.
  - clear_pending is set by CLEAR=1 on any cycle and cleared on entering ERASE.
  - CLEAR asserted during ERASE sets pending again, giving one further erase frame.
  - BUSY=1 exactly while the output stream is in an ERASE frame, aligned with FRAME_START.
  - OFFSET is held during ERASE; ticks are discarded.
- Simultaneous CLEAR and tick at a boundary: ERASE wins and the offset is not stepped.

Test Plan:
Bench parameters for all scenarios: H_RES=16, V_RES=12, NUM_LANES=2, LANE_X0=2, LANE_PITCH=8, LANE_WIDTH=2, INTERVAL=6, STRIPE_LEN=2, PRESCALE=3.
- Reset and mid-frame reset:
  - RESET held -> WE=0, DATA_OUT=1, ADDR=0, OFFSET=0.
  - First edge after release -> ADDR=0, FRAME_START=1.
  - RESET pulse at ADDR={5,7} -> all outputs return to reset values immediately.
- Static pattern, ENABLE=0:
  - Rows 0,1,6,7 at x=2,3,10,11 -> WE=1, DATA_OUT=0.
  - Rows 2-5 and 8-11 at those x -> WE=1, DATA_OUT=1.
  - x=5 -> WE=0.
  - OFFSET stays 0 over 3 frames.
- Down scroll, ENABLE=1, DIR=0, SPEED=1 -> OFFSET 0,1,2 on successive frames; frame with OFFSET=1 has dark rows 1,2,7,8.
- Wrap and clamp:
  - OFFSET=5, SPEED=2, DIR=0 -> 1.
  - Then DIR=1, SPEED=3 -> 4.
  - SPEED=9, DIR=0 from 4 -> 3 (step clamped to 5).
- Erase:
  - CLEAR pulse mid-frame -> next full frame has BUSY=1, all lane pixels WE=1/DATA_OUT=1, OFFSET held.
  - Following frame -> BUSY=0, stripes resume at the same OFFSET.
- Simultaneous events: CLEAR=1 on the boundary cycle with tick pending -> ERASE frame, OFFSET unchanged.
